// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the decode-side hazard controller.
package hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_W-1:0] REG_RA   = 5'd31;

   // One in-flight instruction as seen by the tracker.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             load;
   } trk_entry_t;

   typedef enum logic [0:0] {
      StRun,
      StStall
   } hz_state_e;

   localparam trk_entry_t BUBBLE = '{valid: 1'b0, dest: REG_ZERO, load: 1'b0};

   // r0 never matches: a write to it is architecturally discarded.
   function automatic logic entry_hit(trk_entry_t e, logic [REG_W-1:0] addr);
      return (addr != REG_ZERO) && e.valid && (e.dest != REG_ZERO) && (e.dest == addr);
   endfunction

endpackage

// File: rtl/hazard_ctrl_fw_mux.sv
// Per-operand forwarding select: youngest matching stage wins, else register file.
module hazard_ctrl_fw_mux
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] addr_i,
   input  logic [31:0]      rf_data_i,
   input  trk_entry_t       ex_i,
   input  trk_entry_t       mem_i,
   input  trk_entry_t       wb_i,
   input  logic [31:0]      ex_data_i,
   input  logic [31:0]      mem_data_i,
   input  logic [31:0]      wb_data_i,
   output logic [31:0]      data_o,
   output logic             ex_load_hit_o,
   output logic             mem_load_hit_o
);

   logic hit_ex, hit_mem, hit_wb;

   // Match detection and priority select.
   always_comb begin
      hit_ex  = entry_hit(ex_i, addr_i);
      hit_mem = entry_hit(mem_i, addr_i);
      hit_wb  = entry_hit(wb_i, addr_i);

      // A load in EX has no data yet; the value selected then is a don't-care
      // because decode is stalled, so fall through to the older stages.
      if (hit_ex && !ex_i.load) begin
         data_o = ex_data_i;
      end else if (hit_mem) begin
         data_o = mem_data_i;
      end else if (hit_wb) begin
         data_o = wb_data_i;
      end else begin
         data_o = rf_data_i;
      end

      ex_load_hit_o  = hit_ex && ex_i.load;
      mem_load_hit_o = hit_mem && mem_i.load;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-side hazard controller: destination tracker, operand forwarding and
// load-use stall sequencing.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_STALL = 1,
   parameter int unsigned NREGS_LOG2 = REG_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREGS_LOG2-1:0] id_fw_regdest,
   input  logic                  id_fw_writereg,
   input  logic                  id_fw_load,
   input  logic [NREGS_LOG2-1:0] id_fw_addra,
   input  logic [NREGS_LOG2-1:0] id_fw_addrb,
   input  logic [31:0]           id_fw_rega,
   input  logic [31:0]           id_fw_regb,
   input  logic [31:0]           ex_fw_result,
   input  logic [31:0]           mem_fw_data,
   input  logic [31:0]           wb_fw_data,
   output logic [31:0]           fw_id_rega,
   output logic [31:0]           fw_id_regb,
   output logic                  fw_if_id_stall
);

   trk_entry_t ex_q, mem_q, wb_q, ex_d;
   trk_entry_t ex_v, mem_v, wb_v;
   hz_state_e  state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       ex_ld_a, ex_ld_b, mem_ld_a, mem_ld_b;
   logic       hazard;
   logic       stall;

   // Entries seen by the muxes are masked while reset is high so decode gets
   // plain register-file values before the tracker has been cleared.
   always_comb begin
      ex_v        = ex_q;
      mem_v       = mem_q;
      wb_v        = wb_q;
      ex_v.valid  = ex_q.valid && !reset;
      mem_v.valid = mem_q.valid && !reset;
      wb_v.valid  = wb_q.valid && !reset;
   end

   hazard_ctrl_fw_mux u_fw_mux_a (
      .addr_i         (id_fw_addra),
      .rf_data_i      (id_fw_rega),
      .ex_i           (ex_v),
      .mem_i          (mem_v),
      .wb_i           (wb_v),
      .ex_data_i      (ex_fw_result),
      .mem_data_i     (mem_fw_data),
      .wb_data_i      (wb_fw_data),
      .data_o         (fw_id_rega),
      .ex_load_hit_o  (ex_ld_a),
      .mem_load_hit_o (mem_ld_a)
   );

   hazard_ctrl_fw_mux u_fw_mux_b (
      .addr_i         (id_fw_addrb),
      .rf_data_i      (id_fw_regb),
      .ex_i           (ex_v),
      .mem_i          (mem_v),
      .wb_i           (wb_v),
      .ex_data_i      (ex_fw_result),
      .mem_data_i     (mem_fw_data),
      .wb_data_i      (wb_fw_data),
      .data_o         (fw_id_regb),
      .ex_load_hit_o  (ex_ld_b),
      .mem_load_hit_o (mem_ld_b)
   );

   // Load-use detection; with two bubbles a load still in MEM also blocks.
   always_comb begin
      hazard = ex_ld_a || ex_ld_b;
      if (LOAD_STALL >= 2) begin
         hazard = hazard || mem_ld_a || mem_ld_b;
      end
   end

   // State register for the stall sequencer.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StRun;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: RUN enters STALL only when more than one bubble is needed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StRun: begin
            if (hazard && (LOAD_STALL > 1)) begin
               state_d = StStall;
               cnt_d   = 2'(LOAD_STALL - 1);
            end
         end
         StStall: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // Outputs: stall request and the entry that enters EX at the next edge.
   always_comb begin
      stall = !reset && ((state_q == StStall) || hazard);
      if (stall) begin
         ex_d = BUBBLE;
      end else begin
         ex_d.valid = id_fw_writereg && (id_fw_regdest != REG_ZERO);
         ex_d.dest  = id_fw_regdest;
         ex_d.load  = id_fw_load;
      end
   end

   assign fw_if_id_stall = stall;

   // Tracker shift: EX -> MEM -> WB every cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         ex_q  <= BUBBLE;
         mem_q <= BUBBLE;
         wb_q  <= BUBBLE;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that sits beside the decode stage.
- Tracks the destination registers of in-flight instructions in EX, MEM and WB, and selects forwarded operand values for decode (fw_id_rega/fw_id_regb).
- Sequences load-use stalls through fw_if_id_stall, inserting bubbles into its own tracker while decode is held.
- Forwarding, stall and compare inputs to decode all come from this block.

Parameters:
- LOAD_STALL, 1, bubbles inserted on a load-use hazard; legal range 1..2.
- NREGS_LOG2, 5, register address width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_fw_regdest  in  5  destination register of the instruction in decode
- id_fw_writereg  in  1  decode instruction writes a register
- id_fw_load  in  1  decode instruction is a load
- id_fw_addra  in  5  rs address
- id_fw_addrb  in  5  rt address
- id_fw_rega  in  32  register-file value for rs
- id_fw_regb  in  32  register-file value for rt
- ex_fw_result  in  32  ALU/shift result currently in EX
- mem_fw_data  in  32  value leaving MEM (load data or passed ALU result)
- wb_fw_data  in  32  value being written back
- fw_id_rega  out  32  resolved rs operand
- fw_id_regb  out  32  resolved rt operand
- fw_if_id_stall  out  1  hold IF/ID; bubble into EX

Behaviour:
- Tracker: three entries, EX, MEM and WB. Each entry holds {valid, dest[4:0], load}.
- Every rising edge, WB<=MEM and MEM<=EX.
- EX is loaded with {id_fw_writereg, id_fw_regdest, id_fw_load} when not stalling, or with a bubble (valid=0) when stalling.
- Entries with dest==0 are treated as invalid.
- Forward match, per operand: addr!=0 and entry.valid and entry.dest==addr.
- Priority EX > MEM > WB, otherwise the register-file value:
  - EX match and not load: ex_fw_result.
  - MEM match: mem_fw_data.
  - WB match: wb_fw_data.
  - No match: id_fw_reg*.
- Forwarding is purely combinational, with zero cycles of latency.
- Hazard: EX entry is a load and matches rs or rt. Also, when LOAD_STALL=2, MEM entry is a load and matches.
- FSM states: RUN, STALL. Counter cnt has 2 bits.
- RUN:
  - With a hazard, fw_if_id_stall=1 combinationally in the same cycle, and a bubble enters EX at the edge.
  - If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1; otherwise stay in RUN.
  - Hazard is re-evaluated every cycle, so a stalled instruction is re-checked against the advanced tracker.
- STALL:
  - fw_if_id_stall=1 and a bubble is inserted each cycle.
  - cnt decrements each cycle; at cnt==1 go to RUN.
- During a stall, forwarded outputs still reflect the current tracker; decode ignores them.
- Reset:
  - All tracker entries invalid, state RUN, cnt=0.
  - fw_if_id_stall forced to 0 while reset is high.
  - fw_id_reg* pass id_fw_reg* while reset is high, since all entries are invalid.
- Reset asserted mid-stall aborts the stall; no residual bubbles follow the release of reset.
- Simultaneous matches in several stages: the youngest (EX) wins. Non-writing instructions never create a match.
- Both operands hazarded by the same load produce a single stall sequence, not two.

Decomposition:
- Shared package holds:
  - The tracker-entry struct {valid, dest, load}.
  - FSM state encoding RUN/STALL.
  - Constants REG_ZERO=5'd0 and REG_RA=5'd31.
- One sub-module, fw_mux: a per-operand priority match and select. It is instantiated twice, for rs and rt.

Test Plan:
1. ALU-ALU forwarding:
   - Stimulus: write r5 (ex_fw_result=0x11), next instruction reads rs=5 with regfile value 0x0.
   - Required: fw_id_rega=0x11, no stall.
2. Load-use, LOAD_STALL=1:
   - Stimulus: load r7, then read rt=7.
   - Required: fw_if_id_stall=1 for exactly 1 cycle. Next cycle the MEM match gives fw_id_regb=mem_fw_data (0xDEAD).
3. Priority:
   - Stimulus: r3 written in EX (0xA), MEM (0xB) and WB (0xC).
   - Required: 0xA. After EX retires, 0xB; then 0xC.
4. Register zero:
   - Stimulus: tracker entries with dest=0 and data 0xFFFF, decode reads r0.
   - Required: fw_id_rega=id_fw_rega=0, no stall.
5. LOAD_STALL=2 with reset mid-stall:
   - Stimulus: load r4 then read r4, giving a 2-cycle stall. Assert reset on the 2nd stall cycle.
   - Required: stall drops while reset is high, state RUN, tracker empty, no stall after reset release.
6. Dual-operand hazard:
   - Stimulus: load r9, then an instruction reading rs=9 and rt=9.
   - Required: a single 1-cycle stall, after which both outputs equal mem_fw_data.
